lock_code_sender: RTL
=====================

Name: lock_code_sender

Overview:
- Serial code-entry driver for the combination-lock entry interface. It is the transmit side of the lock's bit/strobe receiver.
- Per attempt it pulses an arm (lock-mode) strobe, then serializes a WIDTH-bit code MSB first as one-cycle bit strobes, then watches the lock's `unlocked` flag.
- Single mode sends one supplied code.
- Sweep mode brute-forces codes 0..2^WIDTH-1 until the lock opens. It is used for self-test and lab demo of the lock block.

Parameters:
- WIDTH, 6, code length in bits. Matches the lock's shift-register width.
- GAP, 2, idle cycles after every arm/bit strobe. Legal range is 1 or more.
- SETTLE, 3, cycles `unlocked` is sampled after the last bit's gap.

Ports:
- hz100  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin operation. Sampled only in IDLE.
- sweep  in  1  mode select. Sampled with start: 0 = single, 1 = sweep.
- code  in  WIDTH  code to send in single mode. Sampled with start.
- unlocked  in  1  lock-open indication from the receiver.
- arm_stb  out  1  one-cycle strobe putting the lock into LOCK/entry mode.
- bit_stb  out  1  one-cycle bit-entry strobe.
- bit_val  out  1  bit value. Valid while bit_stb=1, otherwise 0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  lock opened during the last operation. Holds until the next accepted start.
- found_code  out  WIDTH  code that opened the lock. Holds until the next accepted start.
- attempts  out  WIDTH+1  count of completed attempts. Cleared on an accepted start.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, internal current code 0.
- States: IDLE, ARM, SEND, WAIT.
- IDLE:
  - start=1 at edge N latches sweep and code.
  - Current code becomes `code` in single mode, 0 in sweep mode.
  - Clears found, found_code and attempts; busy=1 from cycle N+1.
  - start while busy=1 is ignored.
- ARM: arm_stb=1 in cycle N+1, then GAP idle cycles.
- SEND:
  - For k=0..WIDTH-1, bit_stb=1 with bit_val=cur[WIDTH-1-k] in cycle N+1+(GAP+1)(k+1).
  - Each strobe is followed by GAP idle cycles with bit_stb=0 and bit_val=0.
  - Sending MSB first leaves the code correctly ordered in the receiver's left-shift register.
- WAIT:
  - Lasts SETTLE cycles; `unlocked` is sampled at each of those edges.
  - `unlocked` outside WAIT is ignored.
  - Any sample high sets found=1 and found_code=cur.
- End of WAIT:
  - attempts increments.
  - Single mode: go to IDLE.
  - Sweep mode: go to IDLE if found=1 or cur is all ones. Otherwise cur+1 and the next ARM strobe starts the next cycle.
- Going to IDLE: done=1 and busy=0 in the same cycle.
- Attempt period P = (1+GAP)(WIDTH+1)+SETTLE, which is 24 at the defaults.
  - Single mode: done occurs in cycle N+1+P.
  - Sweep mode ending after attempt m: done occurs in cycle N+1+m·P.
- Width rules:
  - attempts is WIDTH+1 bits, so a full sweep reaching 2^WIDTH cannot overflow.
  - cur never wraps, because the sweep stops at all ones.
- Only one strobe output is high in any cycle.
- Reset mid-operation: at the next edge every output is 0 and the state is IDLE. No further strobes are issued. Any partially-sent code is abandoned.
- start and reset high together: reset wins.
- GAP=0 is illegal. Simulation assertion: at elaboration.

Test Plan:
- Reset asserted 2 cycles mid-run -> all outputs 0 on the following cycle; no strobes afterwards; next start behaves normally.
- Single, code=6'b101011, unlocked=0, start at edge N -> arm_stb at N+1; bit_stb at N+4,7,10,13,16,19 with bit_val 1,0,1,0,1,1; done at N+25; found=0; attempts=1.
- Same single send with unlocked pulsed in cycle N+23 -> found=1, found_code=6'b101011, done at N+25. An unlocked pulse instead at N+10 (during SEND) -> found=0.
- Sweep against a behavioural lock with password 6'd5 -> codes 0..5 sent in order; found=1, found_code=5, attempts=6; done at N+1+6·24=N+145; no arm_stb after done.
- Sweep with unlocked tied 0 -> last code sent 6'b111111; attempts=64; found=0; done at N+1+64·24=N+1537.
- start re-pulsed while busy, plus sweep/code changes mid-run -> ignored; strobe sequence and results identical to an undisturbed run.

Source files
------------

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - serial code-entry driver for the combination lock
// Per attempt: arm strobe, WIDTH MSB-first bit strobes, then SETTLE cycles watching unlocked.
module lock_code_sender #(
  parameter int WIDTH  = 6,
  parameter int GAP    = 2,
  parameter int SETTLE = 3
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic             sweep,
  input  logic [WIDTH-1:0] code,
  input  logic             unlocked,
  output logic             arm_stb,
  output logic             bit_stb,
  output logic             bit_val,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] found_code,
  output logic [WIDTH:0]   attempts
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam int CNT_MAX = (GAP > SETTLE) ? GAP : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] GAP_C    = CW'(GAP);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  if (GAP < 1) begin : g_bad_gap
    $error("lock_code_sender: GAP must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sweep_q, sweep_d;
  logic             arm_stb_q, arm_stb_d;
  logic             bit_stb_q, bit_stb_d;
  logic             bit_val_q, bit_val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] found_code_q, found_code_d;
  logic [WIDTH:0]   attempts_q, attempts_d;

  // cnt_q counts the idle cycles left in the current strobe slot (or WAIT window)
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    cur_d        = cur_q;
    sh_d         = sh_q;
    sweep_d      = sweep_q;
    arm_stb_d    = 1'b0;
    bit_stb_d    = 1'b0;
    bit_val_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    found_d      = found_q;
    found_code_d = found_code_q;
    attempts_d   = attempts_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ARM;
          cnt_d        = GAP_C;
          arm_stb_d    = 1'b1;
          busy_d       = 1'b1;
          sweep_d      = sweep;
          cur_d        = sweep ? '0 : code;
          found_d      = 1'b0;
          found_code_d = '0;
          attempts_d   = '0;
        end
      end
      ST_ARM: begin
        if (cnt_q == '0) begin
          state_d   = ST_SEND;
          cnt_d     = GAP_C;
          bit_cnt_d = '0;
          bit_stb_d = 1'b1;
          bit_val_d = cur_q[WIDTH-1];
          sh_d      = cur_q << 1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SEND: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_WAIT;
          cnt_d   = SETTLE_C;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          cnt_d     = GAP_C;
          bit_stb_d = 1'b1;
          bit_val_d = sh_q[WIDTH-1];
          sh_d      = sh_q << 1;
        end
      end
      default: begin
        if (unlocked) begin
          found_d      = 1'b1;
          found_code_d = cur_q;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          attempts_d = attempts_q + (WIDTH+1)'(1);
          // the sweep stops at all ones, so cur_q never wraps
          if (!sweep_q || found_d || (&cur_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_ARM;
            cnt_d     = GAP_C;
            cur_d     = cur_q + WIDTH'(1);
            arm_stb_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      cur_q        <= '0;
      sh_q         <= '0;
      sweep_q      <= 1'b0;
      arm_stb_q    <= 1'b0;
      bit_stb_q    <= 1'b0;
      bit_val_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      found_code_q <= '0;
      attempts_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      cur_q        <= cur_d;
      sh_q         <= sh_d;
      sweep_q      <= sweep_d;
      arm_stb_q    <= arm_stb_d;
      bit_stb_q    <= bit_stb_d;
      bit_val_q    <= bit_val_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      found_code_q <= found_code_d;
      attempts_q   <= attempts_d;
    end
  end

  assign arm_stb    = arm_stb_q;
  assign bit_stb    = bit_stb_q;
  assign bit_val    = bit_val_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign found_code = found_code_q;
  assign attempts   = attempts_q;

endmodule
